sys_rst_seq: RTL and testbench
==============================

SYS_RST_SEQ -- requirements
Module: sys_rst_seq

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16, width in clk cycles of each PLL reset pulse.
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536, the maximum clk cycles to wait for lock before re-pulsing PLL reset.
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, the consecutive synchronized-locked cycles required before reset release begins.
REQ-004 SHALL have parameter RST_HOLD_CYCLES, default 64, the extra cycles sys_rst_n stays low after lock is stable.
REQ-005 clk  input  1  free-running 50 MHz board reference clock, the same clock that feeds the PLL refclk; never a PLL output.
REQ-006 rst_n  input  1  asynchronous, active-low reset; one clock domain only.
REQ-007 pll_locked  input  1  PLL locked indication, asynchronous to clk.
REQ-008 sw_rst  input  1  synchronous single-cycle software reset request.
REQ-009 pll_rst  output  1  active-high reset to PLL rst input.
REQ-010 sys_rst_n  output  1  active-low system reset for PLL-clocked logic; each consumer domain resynchronizes it.
REQ-011 lock_loss_cnt  output  8  saturating count of lock losses seen in RUN.
REQ-012 retry_cnt  output  8  saturating count of lock timeouts.
REQ-013 fsm_state  output  3  current state encoding: PLL_RST=0, WAIT_LOCK=1, STABLE=2, HOLD=3, RUN=4.

Function
REQ-014 SHALL synchronize pll_locked through a 2-flop synchronizer (locked_s), reset to 0; all decisions use locked_s only.
REQ-015 SHALL use one down/up counter of width ceil(log2(max parameter))+1, cleared on every state entry.
REQ-016 PLL_RST: pll_rst=1 and sys_rst_n=0; after exactly PLL_RST_CYCLES cycles in state -> WAIT_LOCK.
REQ-017 WAIT_LOCK: pll_rst=0 and sys_rst_n=0; locked_s=1 -> STABLE; counter reaching LOCK_TIMEOUT_CYCLES without lock -> PLL_RST, retry_cnt+1.
REQ-018 STABLE: sys_rst_n=0; locked_s=0 on any cycle -> WAIT_LOCK with counter cleared, no retry increment; LOCK_STABLE_CYCLES consecutive locked cycles -> HOLD.
REQ-019 HOLD: sys_rst_n=0; locked_s=0 -> PLL_RST, lock_loss_cnt+1; after RST_HOLD_CYCLES cycles -> RUN.
REQ-020 RUN: sys_rst_n=1 registered output, deasserting on the first cycle in RUN; locked_s=0 -> PLL_RST with sys_rst_n=0 in that same next cycle, lock_loss_cnt+1.
REQ-021 sw_rst=1 in RUN -> HOLD, sys_rst_n=0 the next cycle, PLL not reset; sw_rst is ignored in all other states.
REQ-022 Simultaneous locked_s=0 and sw_rst=1 in RUN: lock loss wins (-> PLL_RST).
REQ-023 lock_loss_cnt and retry_cnt SHALL saturate at 255 and never wrap.
REQ-024 All outputs SHALL be registered; sys_rst_n SHALL be glitch-free and SHALL never pulse high outside RUN.

Reset
REQ-025 rst_n low SHALL asynchronously force: state PLL_RST, pll_rst=1, sys_rst_n=0, counter=0, locked_s synchronizer=0, lock_loss_cnt=0, retry_cnt=0, fsm_state=0.
REQ-026 After rst_n deasserts, the first PLL_RST interval SHALL last exactly PLL_RST_CYCLES full cycles.
REQ-027 rst_n asserted mid-operation (any state) SHALL apply REQ-025 immediately, and sys_rst_n SHALL drop low without waiting for a clk edge.

Verification (params PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, RST_HOLD_CYCLES=4)
REQ-028 Release rst_n with pll_locked=1 held -> pll_rst high exactly 4 cycles; sys_rst_n rises at 4+2+8+4 (+/-1 for synchronizer phase) cycles and stays high; both counters 0.
REQ-029 pll_locked held 0 for 80 cycles -> pll_rst re-pulses every 36 cycles; retry_cnt=2; sys_rst_n stays 0.
REQ-030 pll_locked glitches low 1 cycle midway through STABLE -> return to WAIT_LOCK; full 8-cycle stability is required again; retry_cnt unchanged.
REQ-031 pll_locked drops in RUN -> sys_rst_n low within 3 cycles, pll_rst pulses 4 cycles, lock_loss_cnt=1; same cycle with sw_rst=1 gives the identical result.
REQ-032 sw_rst pulse in RUN -> sys_rst_n low for exactly 4 cycles, pll_rst stays 0; 300 forced lock losses -> lock_loss_cnt=255.

Source files
------------

// File: rtl/sys_rst_seq_if.sv
// Status/control bundle between the reset sequencer and its surroundings.
interface sys_rst_seq_if;
    localparam int unsigned STAT_W  = 8;
    localparam int unsigned STATE_W = 3;

    logic               pll_locked;
    logic               sw_rst;
    logic               pll_rst;
    logic               sys_rst_n;
    logic [STAT_W-1:0]  lock_loss_cnt;
    logic [STAT_W-1:0]  retry_cnt;
    logic [STATE_W-1:0] fsm_state;

    // Environment side: drives lock/sw request, observes resets and status.
    modport master (
        output pll_locked, sw_rst,
        input  pll_rst, sys_rst_n, lock_loss_cnt, retry_cnt, fsm_state
    );

    // Sequencer side.
    modport slave (
        input  pll_locked, sw_rst,
        output pll_rst, sys_rst_n, lock_loss_cnt, retry_cnt, fsm_state
    );
endinterface

// File: rtl/sys_rst_seq.sv
// PLL reset / lock-qualification sequencer producing a clean system reset.
module sys_rst_seq #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned RST_HOLD_CYCLES     = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    sys_rst_seq_if.slave  bus
);

    localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                      PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_CD  = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                                      LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
    localparam int unsigned MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = $clog2(MAX_ALL) + 1;
    localparam int unsigned STAT_W  = 8;

    localparam logic [CNT_W-1:0]  PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [STAT_W-1:0] STAT_MAX     = '1;

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_HOLD      = 3'd3,
        S_RUN       = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sync1_q, sync1_d;
    logic                locked_s_q, locked_s_d;
    logic                pll_rst_q, pll_rst_d;
    logic                sys_rst_n_q, sys_rst_n_d;
    logic [STAT_W-1:0]   loss_q, loss_d;
    logic [STAT_W-1:0]   retry_q, retry_d;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == STAT_MAX) ? v : v + STAT_W'(1);
    endfunction

    // State, counter, synchronizer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_PLL_RST;
            cnt_q       <= '0;
            sync1_q     <= 1'b0;
            locked_s_q  <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            loss_q      <= '0;
            retry_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync1_q     <= sync1_d;
            locked_s_q  <= locked_s_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            loss_q      <= loss_d;
            retry_q     <= retry_d;
        end
    end

    // Next-state, counter and output decode; outputs follow the next state so they stay registered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        loss_d     = loss_q;
        retry_d    = retry_q;
        sync1_d    = bus.pll_locked;
        locked_s_d = sync1_q;

        unique case (state_q)
            S_PLL_RST: begin
                if (cnt_q == PLL_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked_s_q) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_PLL_RST;
                    retry_d = sat_inc(retry_q);
                end
            end
            S_STABLE: begin
                if (!locked_s_q)                 state_d = S_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST)   state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!locked_s_q) begin
                    state_d = S_PLL_RST;
                    loss_d  = sat_inc(loss_q);
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Counter is idle in RUN; lock loss takes priority over a software request.
                cnt_d = cnt_q;
                if (!locked_s_q) begin
                    state_d = S_PLL_RST;
                    loss_d  = sat_inc(loss_q);
                end else if (bus.sw_rst) begin
                    state_d = S_HOLD;
                end
            end
            default: state_d = S_PLL_RST;
        endcase

        if (state_d != state_q) cnt_d = '0;

        pll_rst_d   = (state_d == S_PLL_RST);
        sys_rst_n_d = (state_d == S_RUN);
    end

    assign bus.pll_rst       = pll_rst_q;
    assign bus.sys_rst_n     = sys_rst_n_q;
    assign bus.lock_loss_cnt = loss_q;
    assign bus.retry_cnt     = retry_q;
    assign bus.fsm_state     = state_q;

endmodule

// File: tb/tb_sys_rst_seq.sv
// Scoreboard bench: a timeline model predicts reset-edge events; a monitor checks them.
module tb_sys_rst_seq;

    localparam int P = 4;
    localparam int T = 32;
    localparam int S = 8;
    localparam int H = 4;

    localparam int K_PLL_RISE = 0;
    localparam int K_PLL_FALL = 1;
    localparam int K_SYS_RISE = 2;
    localparam int K_SYS_FALL = 3;

    typedef struct {
        int kind;
        int cyc;
        int loss;
        int retry;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc;
    int   checks = 0;
    int   errors = 0;
    int   m_loss;
    int   m_retry;
    int   run_at;
    logic mon_pll;
    logic mon_sys;
    ev_t  exp_q[$];

    sys_rst_seq_if bus ();

    sys_rst_seq #(
        .PLL_RST_CYCLES      (P),
        .LOCK_TIMEOUT_CYCLES (T),
        .LOCK_STABLE_CYCLES  (S),
        .RST_HOLD_CYCLES     (H)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Edge index since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    function automatic void push_ev(input int kind, input int at);
        ev_t e;
        e.kind  = kind;
        e.cyc   = at;
        e.loss  = m_loss;
        e.retry = m_retry;
        exp_q.push_back(e);
    endfunction

    // PLL reset begun at edge b; first edge whose decision sees lock is first_dec.
    // Each attempt is P cycles of reset then a T-cycle lock window; returns the edge lock is accepted.
    function automatic int relock(input int b, input int first_dec);
        int lo;
        int hi;
        push_ev(K_PLL_FALL, b + P);
        for (int k = 0; k < 10000; k++) begin
            lo = b + P + k * (P + T) + 1;
            hi = b + P + k * (P + T) + T;
            if (first_dec <= hi) return (first_dec > lo) ? first_dec : lo;
            m_retry = sat_inc(m_retry);
            push_ev(K_PLL_RISE, hi);
            push_ev(K_PLL_FALL, hi + P);
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic observe(input int kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d cyc=%0d", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (kind != e.kind || cyc != e.cyc || int'(bus.lock_loss_cnt) != e.loss ||
                int'(bus.retry_cnt) != e.retry) begin
                errors++;
                $display("FAIL event got kind=%0d cyc=%0d loss=%0d retry=%0d want kind=%0d cyc=%0d loss=%0d retry=%0d",
                         kind, cyc, bus.lock_loss_cnt, bus.retry_cnt, e.kind, e.cyc, e.loss, e.retry);
            end
        end
    endtask

    // Monitor: every change of pll_rst or sys_rst_n out of reset is matched against the queue.
    initial begin
        mon_pll = 1'b1;
        mon_sys = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_pll = bus.pll_rst;
                mon_sys = bus.sys_rst_n;
            end else begin
                if (bus.pll_rst !== mon_pll) begin
                    mon_pll = bus.pll_rst;
                    observe(mon_pll ? K_PLL_RISE : K_PLL_FALL);
                end
                if (bus.sys_rst_n !== mon_sys) begin
                    mon_sys = bus.sys_rst_n;
                    observe(mon_sys ? K_SYS_RISE : K_SYS_FALL);
                end
            end
        end
    end

    task automatic goto(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Lock drop in RUN, optionally with a coincident sw_rst and a later one-cycle glitch in STABLE.
    task automatic do_loss(input bit with_sw, input bit with_glitch, input int max_relock);
        int d;
        int b;
        int c;
        int es;
        int g;
        d = run_at + int'($urandom_range(1, 5));
        b = d + 3;
        c = with_sw ? d + 3 + int'($urandom_range(0, max_relock))
                    : d + 1 + int'($urandom_range(0, max_relock));
        m_loss = sat_inc(m_loss);
        push_ev(K_PLL_RISE, b);
        push_ev(K_SYS_FALL, b);
        es = relock(b, c + 3);
        g  = 0;
        if (with_glitch) begin
            g  = es - 2 + int'($urandom_range(0, S - 3));
            es = g + 4;
        end
        run_at = es + S + H;
        push_ev(K_SYS_RISE, run_at);

        goto(d);
        bus.pll_locked = 1'b0;
        if (with_sw) begin
            goto(d + 2);
            bus.sw_rst = 1'b1;
            goto(d + 3);
            bus.sw_rst = 1'b0;
        end
        goto(c);
        bus.pll_locked = 1'b1;
        if (with_glitch) begin
            goto(g);
            bus.pll_locked = 1'b0;
            goto(g + 1);
            bus.pll_locked = 1'b1;
        end
    endtask

    // Software reset in RUN: H cycles of sys_rst_n low, PLL untouched.
    task automatic do_sw();
        int w;
        w = run_at + int'($urandom_range(1, 6));
        push_ev(K_SYS_FALL, w + 1);
        run_at = w + 1 + H;
        push_ev(K_SYS_RISE, run_at);
        goto(w);
        bus.sw_rst = 1'b1;
        goto(w + 1);
        bus.sw_rst = 1'b0;
    endtask

    initial begin
        int es;
        int c;
        rst_n          = 1'b0;
        bus.pll_locked = 1'b1;
        bus.sw_rst     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pll_rst",   int'(bus.pll_rst), 1);
        chk("rst_sys_rst_n", int'(bus.sys_rst_n), 0);
        chk("rst_fsm_state", int'(bus.fsm_state), 0);
        chk("rst_loss",      int'(bus.lock_loss_cnt), 0);
        chk("rst_retry",     int'(bus.retry_cnt), 0);

        // Lock present from the start.
        m_loss  = 0;
        m_retry = 0;
        rst_n   = 1'b1;
        es      = relock(0, 3);
        run_at  = es + S + H;
        push_ev(K_SYS_RISE, run_at);
        goto(run_at + 3);
        chk("run_sys_rst_n", int'(bus.sys_rst_n), 1);
        chk("run_fsm_state", int'(bus.fsm_state), 4);
        chk("run_loss",      int'(bus.lock_loss_cnt), 0);
        chk("run_retry",     int'(bus.retry_cnt), 0);

        do_loss(1'b0, 1'b0, 10);
        do_loss(1'b1, 1'b0, 10);
        do_loss(1'b0, 1'b1, 4);
        do_loss(1'b1, 1'b1, 60);
        do_sw();
        do_sw();

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) do_sw();
            do_loss(1'($urandom_range(0, 1)), 1'b0, 2);
        end
        goto(run_at + 2);
        chk("loss_saturated", int'(bus.lock_loss_cnt), 255);
        chk("sat_sys_rst_n",  int'(bus.sys_rst_n), 1);

        // Asynchronous reset mid-cycle while running.
        goto(run_at + 4);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_sys_rst_n", int'(bus.sys_rst_n), 0);
        chk("async_pll_rst",   int'(bus.pll_rst), 1);
        chk("async_fsm_state", int'(bus.fsm_state), 0);
        chk("async_loss",      int'(bus.lock_loss_cnt), 0);
        chk("async_retry",     int'(bus.retry_cnt), 0);

        // No lock for a long time: periodic PLL re-pulses, sw_rst ignored outside RUN.
        bus.pll_locked = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        m_loss  = 0;
        m_retry = 0;
        rst_n   = 1'b1;
        c       = 80 + int'($urandom_range(0, 40));
        es      = relock(0, c + 3);
        run_at  = es + S + H;
        push_ev(K_SYS_RISE, run_at);
        goto(1);
        bus.sw_rst = 1'b1;
        goto(2);
        bus.sw_rst = 1'b0;
        goto(10);
        bus.sw_rst = 1'b1;
        goto(11);
        bus.sw_rst = 1'b0;
        goto(80);
        chk("timeout_retry",     int'(bus.retry_cnt), 2);
        chk("timeout_sys_rst_n", int'(bus.sys_rst_n), 0);
        goto(c);
        bus.pll_locked = 1'b1;
        goto(run_at + 3);
        chk("final_sys_rst_n", int'(bus.sys_rst_n), 1);
        chk("queue_empty",     exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
